// File: rtl/neuromorphic_xbar_core_if.sv
// rtl/neuromorphic_xbar_core_if.sv - single-address host strobe bus between the Wishbone shim and the crossbar core
//
// Signals:
//   EN       access strobe, already address-qualified by the shim
//   W_RB     1 = write command word, 0 = read result word
//   DI       32-bit command word
//   DO       32-bit result word
//   core_ack one-cycle access acknowledge
// The shim side uses the master modport; the core uses the slave modport.
interface neuromorphic_xbar_core_if;
   logic        EN;
   logic        W_RB;
   logic [31:0] DI;
   logic [31:0] DO;
   logic        core_ack;

   modport master (output EN, output W_RB, output DI, input DO, input core_ack);
   modport slave  (input EN, input W_RB, input DI, output DO, output core_ack);
endinterface

// File: rtl/neuromorphic_xbar_core.sv
// rtl/neuromorphic_xbar_core.sv - 1-bit weight crossbar with command/result FIFOs and a delay-timed engine
//
// Holds a ROWS x COLS binary weight array. Commands arrive through a command FIFO and are
// executed by a two-state engine: PROGRAM, READ, INFER (masked row popcount) and SETVEC.
// READ/INFER results go to a result FIFO drained by host reads.
//
// Ports:
//   CLKin     core clock
//   RSTin     asynchronous active-low reset (array contents are kept)
//   bus       host strobe bus (EN, W_RB, DI in; DO, core_ack out)
//   busy      engine executing a timed command
//   ip_count  command FIFO occupancy
//   op_count  result FIFO occupancy
//   err       sticky address-range error, cleared by SETVEC with DI[28]=1
module neuromorphic_xbar_core #(
   parameter int         ROWS        = 32,
   parameter int         COLS        = 32,
   parameter int         IFIFO_DEPTH = 32,
   parameter int         OFIFO_DEPTH = 32,
   parameter int         RD_DLY      = 44,
   parameter int         WR_DLY      = 200,
   parameter logic [7:0] THRESH      = 8'h7F
) (
   input  logic                           CLKin,
   input  logic                           RSTin,
   neuromorphic_xbar_core_if.slave        bus,
   output logic                           busy,
   output logic [$clog2(IFIFO_DEPTH):0]   ip_count,
   output logic [$clog2(OFIFO_DEPTH):0]   op_count,
   output logic                           err
);

   localparam int IAW  = $clog2(IFIFO_DEPTH);
   localparam int OAW  = $clog2(OFIFO_DEPTH);
   localparam int MAXD = (RD_DLY > WR_DLY) ? RD_DLY : WR_DLY;
   localparam int CW   = $clog2(MAXD + 1);

   localparam logic [IAW:0]  IDEPTH   = IFIFO_DEPTH[IAW:0];
   localparam logic [OAW:0]  ODEPTH   = OFIFO_DEPTH[OAW:0];
   localparam logic [CW-1:0] RD_LOAD  = CW'(RD_DLY - 1);
   localparam logic [CW-1:0] WR_LOAD  = CW'(WR_DLY - 1);
   localparam logic [5:0]    ROWS_C   = 6'(ROWS);
   localparam logic [5:0]    COLS_C   = 6'(COLS);
   localparam logic [31:0]   COL_MASK = 32'((64'd1 << COLS) - 64'd1);

   localparam logic [1:0] OP_SETVEC = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_INFER  = 2'b10;
   localparam logic [1:0] OP_PROG   = 2'b11;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EXEC = 1'b1;

   localparam logic [31:0] RD_EMPTY_WORD = 32'hDEAD_C0DE;
   localparam logic [31:0] RANGE_ERR_WORD = 32'hBAD0_ADD5;

   // Weight storage is sized to the full 5-bit row/col address fields; cells outside
   // ROWS x COLS are never written and every read of them is replaced by the range-error word.
   logic [31:0]      r_array [32];

   logic [31:0]      r_imem [IFIFO_DEPTH];
   logic [IAW-1:0]   r_iwp, r_irp;
   logic [IAW:0]     r_icnt;

   logic [31:0]      r_omem [OFIFO_DEPTH];
   logic [OAW-1:0]   r_owp, r_orp;
   logic [OAW:0]     r_ocnt;

   logic [0:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic [4:0]       r_row;
   logic [4:0]       r_col;
   logic [7:0]       r_val;
   logic [31:0]      r_spike;
   logic             r_err;
   logic             r_ack;
   logic [31:0]      r_do;

   logic             w_access, w_ifull, w_ofull;
   logic             w_ipush, w_ipop, w_hread, w_opop, w_opush;
   logic             w_start, w_setvec, w_done, w_commit, w_bad;
   logic [31:0]      w_ihead;
   logic [1:0]       w_hop;
   logic             w_hop_query;
   logic [31:0]      w_and;
   logic [5:0]       w_pop;
   logic [31:0]      w_result;
   logic             w_unused;

   // Host side: no access is taken in the cycle following an ack.
   assign w_access = bus.EN & ~r_ack;
   assign w_ifull  = (r_icnt == IDEPTH);
   assign w_ofull  = (r_ocnt == ODEPTH);
   assign w_ipush  = w_access & bus.W_RB & ~w_ifull;
   assign w_hread  = w_access & ~bus.W_RB;
   assign w_opop   = w_hread & (r_ocnt != '0);

   // Engine side
   assign w_ihead     = r_imem[r_irp];
   assign w_hop       = w_ihead[31:30];
   assign w_hop_query = (w_hop == OP_READ) || (w_hop == OP_INFER);
   // Only one result can be in flight, so a free result slot at pop time guarantees room at push.
   assign w_ipop      = (r_state == S_IDLE) && (r_icnt != '0) && (!w_hop_query || !w_ofull);
   assign w_start     = w_ipop && (w_hop != OP_SETVEC);
   assign w_setvec    = w_ipop && (w_hop == OP_SETVEC);
   assign w_done      = (r_state == S_EXEC) && (r_cnt == '0);
   assign w_bad       = ({1'b0, r_row} >= ROWS_C) || ((r_op != OP_INFER) && ({1'b0, r_col} >= COLS_C));
   assign w_commit    = w_done && (r_op == OP_PROG) && !w_bad;
   assign w_opush     = w_done && (r_op != OP_PROG);
   assign w_unused    = ^w_ihead[19:16];

   // Result is formed from the array as it stands at the push edge.
   always_comb begin
      w_and = r_array[r_row] & r_spike & COL_MASK;
      w_pop = '0;
      for (int i = 0; i < 32; i++) begin
         w_pop = w_pop + {5'b0, w_and[i]};
      end
      if (w_bad)
         w_result = RANGE_ERR_WORD;
      else if (r_op == OP_READ)
         w_result = {31'b0, r_array[r_row][r_col]};
      else
         w_result = {26'b0, w_pop};
   end

   always_ff @(posedge CLKin or negedge RSTin) begin
      if (!RSTin) begin
         r_iwp   <= '0;
         r_irp   <= '0;
         r_icnt  <= '0;
         r_owp   <= '0;
         r_orp   <= '0;
         r_ocnt  <= '0;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_SETVEC;
         r_row   <= '0;
         r_col   <= '0;
         r_val   <= '0;
         r_spike <= '0;
         r_err   <= 1'b0;
         r_ack   <= 1'b0;
         r_do    <= '0;
      end else begin
         r_ack <= w_ipush | w_hread;
         if (w_hread)
            r_do <= w_opop ? r_omem[r_orp] : RD_EMPTY_WORD;

         if (w_ipush) r_iwp <= r_iwp + 1'b1;
         if (w_ipop)  r_irp <= r_irp + 1'b1;
         case ({w_ipush, w_ipop})
            2'b10:   r_icnt <= r_icnt + 1'b1;
            2'b01:   r_icnt <= r_icnt - 1'b1;
            default: r_icnt <= r_icnt;
         endcase

         if (w_opush) r_owp <= r_owp + 1'b1;
         if (w_opop)  r_orp <= r_orp + 1'b1;
         case ({w_opush, w_opop})
            2'b10:   r_ocnt <= r_ocnt + 1'b1;
            2'b01:   r_ocnt <= r_ocnt - 1'b1;
            default: r_ocnt <= r_ocnt;
         endcase

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_EXEC;
                  r_op    <= w_hop;
                  r_row   <= w_ihead[29:25];
                  r_col   <= w_ihead[24:20];
                  r_val   <= w_ihead[7:0];
                  r_cnt   <= (w_hop == OP_PROG) ? WR_LOAD : RD_LOAD;
               end
            end
            default: begin
               if (w_done)
                  r_state <= S_IDLE;
               else
                  r_cnt <= r_cnt - 1'b1;
            end
         endcase

         if (w_setvec) begin
            if (w_ihead[29])
               r_spike[31:16] <= w_ihead[15:0];
            else
               r_spike[15:0]  <= w_ihead[15:0];
         end

         // Setting happens only in EXEC and clearing only in IDLE, so they never collide.
         if (w_done && w_bad)
            r_err <= 1'b1;
         else if (w_setvec && w_ihead[28])
            r_err <= 1'b0;
      end
   end

   // Storage without reset: FIFO payloads are discarded by pointer reset, the array is nonvolatile.
   always_ff @(posedge CLKin) begin
      if (w_ipush)
         r_imem[r_iwp] <= bus.DI;
      if (w_opush)
         r_omem[r_owp] <= w_result;
      if (w_commit)
         r_array[r_row][r_col] <= (r_val > THRESH);
   end

   assign bus.DO       = r_do;
   assign bus.core_ack = r_ack;
   assign busy         = (r_state == S_EXEC);
   assign ip_count     = r_icnt;
   assign op_count     = r_ocnt;
   assign err          = r_err;

endmodule

// File: tb/tb_neuromorphic_xbar_core.sv
// tb/tb_neuromorphic_xbar_core.sv - self-checking bench for neuromorphic_xbar_core
module tb_neuromorphic_xbar_core;

   localparam int ROWS = 16;
   localparam int COLS = 32;
   localparam int IFD  = 4;
   localparam int OFD  = 2;
   localparam int RDD  = 6;
   localparam int WRD  = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy, err;
   logic [2:0] ip_count;
   logic [1:0] op_count;
   int         cyc = 0;

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] cmd;
      bit          query;
      logic [31:0] exp;
      logic        exp_err;
   } vec_t;
   vec_t tbl[$];

   neuromorphic_xbar_core_if bus ();

   neuromorphic_xbar_core #(
      .ROWS(ROWS), .COLS(COLS), .IFIFO_DEPTH(IFD), .OFIFO_DEPTH(OFD),
      .RD_DLY(RDD), .WR_DLY(WRD), .THRESH(8'h7F)
   ) dut (
      .CLKin(clk), .RSTin(rst_n), .bus(bus), .busy(busy),
      .ip_count(ip_count), .op_count(op_count), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] c_prog(input int r, input int c, input logic [7:0] v);
      logic [4:0] rr = r[4:0];
      logic [4:0] cc = c[4:0];
      return {2'b11, rr, cc, 12'b0, v};
   endfunction
   function automatic logic [31:0] c_read(input int r, input int c);
      logic [4:0] rr = r[4:0];
      logic [4:0] cc = c[4:0];
      return {2'b01, rr, cc, 20'b0};
   endfunction
   function automatic logic [31:0] c_inf(input int r);
      logic [4:0] rr = r[4:0];
      return {2'b10, rr, 25'b0};
   endfunction
   function automatic logic [31:0] c_vec(input logic hi, input logic clr, input logic [15:0] v);
      return {2'b00, hi, clr, 12'b0, v};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic add(input logic [31:0] cmd, input bit q, input logic [31:0] e, input logic ee);
      vec_t v;
      v.cmd = cmd; v.query = q; v.exp = e; v.exp_err = ee;
      tbl.push_back(v);
   endtask

   task automatic host_access(input logic wr, input logic [31:0] d, output logic [31:0] q);
      logic ok = 1'b0;
      q = '0;
      @(negedge clk);
      bus.EN = 1'b1; bus.W_RB = wr; bus.DI = d;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (bus.core_ack) begin ok = 1'b1; q = bus.DO; break; end
      end
      bus.EN = 1'b0;
      if (!ok) chk("ack_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] d);
      logic [31:0] q;
      host_access(1'b1, d, q);
   endtask

   task automatic do_read(input string name);
      logic [31:0] q;
      host_access(1'b0, 32'h0, q);
      if (exp_q.size() == 0) chk({name, "_scoreboard_empty"}, q, 32'hFFFF_FFFF);
      else chk(name, q, exp_q.pop_front());
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (ip_count == 0 && !busy) begin ok = 1'b1; break; end
      end
      if (!ok) chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      logic [31:0] q;
      int t0, t1;
      logic got;

      bus.EN = 1'b0; bus.W_RB = 1'b0; bus.DI = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_do", bus.DO, 32'h0);
      chk("rst_ack", 32'(bus.core_ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ip", 32'(ip_count), 32'h0);
      chk("rst_op", 32'(op_count), 32'h0);
      chk("rst_err", 32'(err), 32'h0);

      // Empty read: ack one cycle later, DEAD_C0DE, ack lasts one cycle
      bus.EN = 1'b1; bus.W_RB = 1'b0;
      @(posedge clk); #1;
      chk("empty_rd_ack", 32'(bus.core_ack), 32'h1);
      chk("empty_rd_do", bus.DO, 32'hDEAD_C0DE);
      bus.EN = 1'b0;
      @(posedge clk); #1;
      chk("ack_one_cycle", 32'(bus.core_ack), 32'h0);

      // Timing: PROGRAM then READ with EN held; result at WR+RD+2 after first ack
      @(negedge clk);
      bus.EN = 1'b1; bus.W_RB = 1'b1; bus.DI = c_prog(3, 5, 8'h80);
      got = 1'b0; t0 = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.core_ack) begin got = 1'b1; t0 = cyc; break; end
      end
      chk("tm_first_ack", 32'(got), 32'h1);
      bus.DI = c_read(3, 5);
      exp_q.push_back(32'h1);
      @(posedge clk); #1;
      chk("tm_alt_noack", 32'(bus.core_ack), 32'h0);
      chk("tm_busy_e1", 32'(busy), 32'h1);
      @(posedge clk); #1;
      chk("tm_second_ack", 32'(bus.core_ack), 32'h1);
      bus.EN = 1'b0;
      got = 1'b0; t1 = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (op_count == 1) begin got = 1'b1; t1 = cyc; break; end
      end
      chk("tm_push_seen", 32'(got), 32'h1);
      chk("tm_latency", 32'(t1 - t0), 32'(WRD + RDD + 2));
      do_read("tm_result");

      // Table-driven vectors
      add(c_prog(3, 5, 8'h80), 0, 0, 0);
      add(c_read(3, 5), 1, 32'h1, 0);
      add(c_prog(3, 6, 8'h7F), 0, 0, 0);
      add(c_read(3, 6), 1, 32'h0, 0);
      for (int c = 0; c < 16; c++) add(c_prog(2, c, (c < 8) ? 8'hFF : 8'h00), 0, 0, 0);
      add(c_vec(1'b0, 1'b0, 16'h00F0), 0, 0, 0);
      add(c_vec(1'b1, 1'b0, 16'h0000), 0, 0, 0);
      add(c_inf(2), 1, 32'd4, 0);
      add(c_vec(1'b0, 1'b0, 16'hFFFF), 0, 0, 0);
      add(c_inf(2), 1, 32'd8, 0);
      add(c_prog(2, 31, 8'h80), 0, 0, 0);
      add(c_vec(1'b1, 1'b0, 16'h8000), 0, 0, 0);
      add(c_inf(2), 1, 32'd9, 0);
      add(c_prog(15, 31, 8'h80), 0, 0, 0);
      add(c_read(15, 31), 1, 32'h1, 0);
      add(c_read(20, 0), 1, 32'hBAD0_ADD5, 1);
      add(c_vec(1'b0, 1'b0, 16'hFFFF), 0, 0, 1);
      add(c_vec(1'b1, 1'b1, 16'h8000), 0, 0, 0);
      add(c_read(16, 0), 1, 32'hBAD0_ADD5, 1);
      add(c_vec(1'b1, 1'b1, 16'h8000), 0, 0, 0);
      add(c_inf(16), 1, 32'hBAD0_ADD5, 1);
      add(c_vec(1'b1, 1'b1, 16'h8000), 0, 0, 0);
      add(c_prog(17, 0, 8'hFF), 0, 0, 1);
      add(c_vec(1'b1, 1'b1, 16'h8000), 0, 0, 0);

      foreach (tbl[i]) begin
         do_write(tbl[i].cmd);
         if (tbl[i].query) exp_q.push_back(tbl[i].exp);
         wait_idle();
         if (tbl[i].query) do_read($sformatf("vec%0d_data", i));
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      end

      // Full command FIFO: engine busy, five writes with EN held
      do_write(c_prog(10, 0, 8'hFF));
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy) begin got = 1'b1; break; end
      end
      chk("ff_busy", 32'(got), 32'h1);
      @(negedge clk);
      bus.EN = 1'b1; bus.W_RB = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         bus.DI = c_prog(10, k, 8'hFF);
         got = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.core_ack) begin got = 1'b1; break; end
         end
         chk($sformatf("ff_ack%0d", k), 32'(got), 32'h1);
      end
      chk("ff_ip_full", 32'(ip_count), 32'd4);
      bus.DI = c_prog(10, 5, 8'hFF);
      got = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus.core_ack) got = 1'b1;
      end
      chk("ff_stall", 32'(got), 32'h0);
      for (int i = 0; i < 4 * WRD; i++) begin
         @(posedge clk); #1;
         if (bus.core_ack) begin got = 1'b1; break; end
      end
      chk("ff_fifth_ack", 32'(got), 32'h1);
      chk("ff_ip_after", 32'(ip_count), 32'd4);
      bus.EN = 1'b0;
      wait_idle();
      do_write(c_read(10, 5));
      exp_q.push_back(32'h1);
      wait_idle();
      do_read("ff_fifth_committed");

      // Full result FIFO: third READ waits until the host pops
      do_write(c_read(3, 5));  exp_q.push_back(32'h1);
      do_write(c_read(3, 6));  exp_q.push_back(32'h0);
      do_write(c_read(15, 31)); exp_q.push_back(32'h1);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (op_count == 2) begin got = 1'b1; break; end
      end
      chk("of_full_seen", 32'(got), 32'h1);
      repeat (RDD + 4) @(posedge clk);
      #1;
      chk("of_ip_waiting", 32'(ip_count), 32'd1);
      chk("of_not_busy", 32'(busy), 32'd0);
      chk("of_op_full", 32'(op_count), 32'd2);
      do_read("of_r1");
      wait_idle();
      do_read("of_r2");
      do_read("of_r3");

      // Reset mid-EXEC of PROGRAM
      do_write(c_prog(4, 4, 8'h7F));
      wait_idle();
      do_write(c_prog(4, 4, 8'h80));
      do_write(c_read(3, 5));
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy) begin got = 1'b1; break; end
      end
      chk("rx_busy", 32'(got), 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rx_ip", 32'(ip_count), 32'd0);
      chk("rx_op", 32'(op_count), 32'd0);
      chk("rx_busy_low", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * WRD) @(posedge clk);
      #1;
      chk("rx_op_after", 32'(op_count), 32'd0);
      do_write(c_read(4, 4)); exp_q.push_back(32'h0);
      wait_idle();
      do_read("rx_bit_unchanged");
      do_write(c_inf(2)); exp_q.push_back(32'h0);
      wait_idle();
      do_read("rx_spike_cleared");
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/neuromorphic_xbar_core.md
# neuromorphic_xbar_core

Parametrised, synthesizable successor to the 32x32 behavioural crossbar core. Holds a ROWS x COLS 1-bit weight array behind a command FIFO and a result FIFO, and executes PROGRAM, READ, INFER (masked row popcount against a loaded spike vector) and SETVEC commands. Commands are timed by a delay-counter FSM. The block sits directly under the Wishbone shim: it sees the single-address EN/W_RB/DI strobe and returns DO/core_ack.

## Interface
Parameters:
- ROWS, 32, array rows (1..32)
- COLS, 32, array columns (1..32)
- IFIFO_DEPTH, 32, command FIFO depth (power of 2, >=2)
- OFIFO_DEPTH, 32, result FIFO depth (power of 2, >=2)
- RD_DLY, 44, cycles from command start to result push for READ/INFER (>=1)
- WR_DLY, 200, cycles from command start to array commit for PROGRAM (>=1)
- THRESH, 8'h7F, PROGRAM threshold; stored bit = (DI[7:0] > THRESH)

Ports (one clock; reset is asynchronous and active-low):
- CLKin  in  1  core clock
- RSTin  in  1  asynchronous active-low reset
- EN  in  1  access strobe (address/select already qualified by shim)
- W_RB  in  1  1 = write command, 0 = read result
- DI  in  32  command word
- DO  out  32  result word
- core_ack  out  1  one-cycle access acknowledge
- busy  out  1  engine executing a timed command
- ip_count  out  $clog2(IFIFO_DEPTH)+1  command FIFO occupancy
- op_count  out  $clog2(OFIFO_DEPTH)+1  result FIFO occupancy
- err  out  1  sticky address-range error

## Operation
- Command decode, DI[31:30]:
  - 11 PROGRAM: row DI[29:25], col DI[24:20], bit from DI[7:0] vs THRESH.
  - 01 READ: result is {31'b0, array[row][col]}.
  - 10 INFER: result is {26'b0, popcount(array row DI[29:25] AND spike_vec[COLS-1:0])}.
  - 00 SETVEC: DI[29]=0 writes spike_vec[15:0]; DI[29]=1 writes spike_vec[31:16], both from DI[15:0]. DI[28]=1 also clears err.
- Out-of-range (row>=ROWS, or col>=COLS for PROGRAM/READ):
  - PROGRAM is dropped.
  - READ/INFER push 32'hBAD0_ADD5.
  - err is set in all three cases.
- Host access: while core_ack=0 and EN=1, the cycle is handled as below. No access is taken on the cycle after an ack, so holding EN gives alternate-cycle acks.
  - Write, ip_count<IFIFO_DEPTH: enqueue DI, ack.
  - Write, command FIFO full: no ack; master stalls.
  - Read, op_count>0: pop into DO, ack.
  - Read, op_count=0: DO=32'hDEAD_C0DE, ack.
- Engine FSM, states IDLE, EXEC:
  - IDLE -> EXEC: ip_count>0 and head is PROGRAM. Pop, load counter, busy=1.
  - IDLE -> EXEC: ip_count>0, head is READ/INFER, and op_count + (op push pending) < OFIFO_DEPTH. Pop, load counter, busy=1.
  - A READ/INFER head with the result FIFO full waits in IDLE, not popped.
  - SETVEC is popped and applied in IDLE in one cycle; it does not enter EXEC.
  - EXEC -> IDLE when the counter expires: PROGRAM commits to the array; READ/INFER pushes its result.
- Array contents are not affected by RSTin (nonvolatile emulation). spike_vec resets to 0.

## Timing
- Reset values: DO=0, core_ack=0, busy=0, ip_count=0, op_count=0, err=0. Both FIFOs empty, FSM in IDLE, spike_vec=0.
- Command write accepted at edge E0 (core_ack high after E0). Engine pops at E1.
- PROGRAM: array updated at edge E1+WR_DLY.
- READ/INFER: result pushed at edge E1+RD_DLY, so op_count increments then.
- busy is high from E1 until the commit/push edge.
- SETVEC: takes effect at E1.
- The array value sampled for READ/INFER is taken at the push edge. A PROGRAM ahead in the queue has always committed first.
- Same-cycle host enqueue and engine pop: ip_count unchanged.
- Same-cycle engine push and host pop: op_count unchanged; the popped word is the oldest.
- FIFO pointers wrap modulo depth. Counts reach DEPTH exactly; there is no overwrite.
- Reset mid-EXEC: the command is abandoned with no array write and no push. All queued commands and results are discarded.

## Test plan
- Reset, then host read -> ack one cycle later with DO=32'hDEAD_C0DE; all status outputs 0.
- Timing: PROGRAM r3,c5, DI[7:0]=8'h80, then READ r3,c5 -> result 32'h1 at op_count rise, exactly WR_DLY+RD_DLY+2 cycles after the first ack; READ with DI[7:0]=8'h7F programmed -> 32'h0.
- INFER: program row 2 cols 0..7 to 1; SETVEC lo=16'h00F0, hi=0; INFER r2 -> 32'd4.
- Range error: with ROWS=16, READ r20 -> 32'hBAD0_ADD5 and err=1; SETVEC with DI[28]=1 -> err=0.
- Full command FIFO: IFIFO_DEPTH=4, five writes with EN held and engine busy -> fifth gets no ack until a pop. Full result FIFO: OFIFO_DEPTH=2, three READs -> third stays queued until the host pops.
- Reset mid-EXEC of PROGRAM -> target bit unchanged afterwards; ip_count=0, op_count=0.
